// File: rtl/bsg_counter_overflow_event_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_counter_overflow_event_pkg
//  Purpose  : Shared types and constants for the overflow-event block.
//  Revision : 1.0 - initial release
// ============================================================================
package bsg_counter_overflow_event_pkg;

   // Event FSM states
   typedef enum logic [1:0] {
      eDisarmed = 2'd0,
      eArmed    = 2'd1,
      eFull     = 2'd2
   } bsg_overflow_event_state_e;

   // Width of the optional lost-wrap counter
   localparam int c_drop_count_width = 16;

endpackage
`default_nettype wire

// File: rtl/bsg_counter_up_down.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_counter_up_down
//  Purpose  : Saturating up/down counter, 0..max_val_p. Simultaneous up and
//             down leave the count unchanged. Exposes the next count so the
//             owner can make decisions on it without an extra cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module bsg_counter_up_down #(
   parameter int max_val_p = 15,
   parameter int width_p   = $clog2(max_val_p + 1)
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               up_i,
   input  logic               down_i,
   output logic [width_p-1:0] count_o,
   output logic [width_p-1:0] count_next_o
);

   localparam logic [width_p-1:0] c_max = width_p'(max_val_p);

   logic [width_p-1:0] r_count;
   logic [width_p-1:0] w_count_next;

   // Next count: clamp at both ends so the counter never wraps
   always_comb begin
      w_count_next = r_count;
      if (up_i && !down_i && (r_count != c_max)) begin
         w_count_next = r_count + 1'b1;
      end else if (down_i && !up_i && (r_count != '0)) begin
         w_count_next = r_count - 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_next;
      end
   end

   assign count_o      = r_count;
   assign count_next_o = w_count_next;

endmodule
`default_nettype wire

// File: rtl/bsg_counter_overflow_event.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_counter_overflow_event
//  Purpose  : Turns one-cycle counter-wrap pulses into epoch-numbered tokens
//             on a valid/yumi interface, buffering up to 2^pending_width_p-1
//             undelivered wraps and flagging any that are lost.
//  Options  : BSG_COUNTER_OVERFLOW_EVENT_DROP_COUNT_EN adds drop_count_o, a
//             saturating count of lost wraps.
//  Revision : 1.0 - initial release
// ============================================================================
module bsg_counter_overflow_event
   import bsg_counter_overflow_event_pkg::*;
#(
   parameter int pending_width_p = 4,
   parameter int epoch_width_p   = 16
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       overflow_i,
   input  logic                       arm_i,
   input  logic                       disarm_i,
   input  logic                       clear_i,
   output logic                       v_o,
   output logic [epoch_width_p-1:0]   epoch_o,
   input  logic                       yumi_i,
   output logic [pending_width_p-1:0] pending_o,
   output logic                       dropped_o
`ifdef BSG_COUNTER_OVERFLOW_EVENT_DROP_COUNT_EN
  ,output logic [c_drop_count_width-1:0] drop_count_o
`endif
);

   localparam int                         c_pending_max_int = (1 << pending_width_p) - 1;
   localparam logic [pending_width_p-1:0] c_pending_max     = '1;

   bsg_overflow_event_state_e   r_state;
   logic [epoch_width_p-1:0]    r_epoch;
   logic                        r_dropped;
   logic [pending_width_p-1:0]  w_pending;
   logic [pending_width_p-1:0]  w_pending_next;
   logic                        w_yumi;
   logic                        w_up;
   logic                        w_drop;

   // A yumi with nothing buffered is illegal and is simply ignored here
   assign w_yumi = yumi_i & (w_pending != '0);

   // In FULL an overflow is only absorbed when a token leaves the same cycle
   assign w_up   = overflow_i & ((r_state == eArmed) | ((r_state == eFull) & w_yumi));
   assign w_drop = overflow_i & (r_state == eFull) & ~w_yumi;

   bsg_counter_up_down #(
      .max_val_p (c_pending_max_int),
      .width_p   (pending_width_p)
   ) u_pending (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .up_i         (w_up),
      .down_i       (w_yumi),
      .count_o      (w_pending),
      .count_next_o (w_pending_next)
   );

   // Arm/disarm FSM; FULL tracks whether the next pending count is at maximum
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state <= eDisarmed;
      end else if (disarm_i) begin
         r_state <= eDisarmed;
      end else begin
         case (r_state)
            eDisarmed: begin
               if (arm_i) begin
                  r_state <= (w_pending_next == c_pending_max) ? eFull : eArmed;
               end
            end
            eArmed, eFull: begin
               r_state <= (w_pending_next == c_pending_max) ? eFull : eArmed;
            end
            default: r_state <= eDisarmed;
         endcase
      end
   end

   // Epoch advances once per delivered token, wrapping naturally
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_epoch <= '0;
      end else if (w_yumi) begin
         r_epoch <= r_epoch + 1'b1;
      end
   end

   // Sticky drop flag; a new drop outranks a same-cycle clear
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_dropped <= 1'b0;
      end else if (w_drop) begin
         r_dropped <= 1'b1;
      end else if (clear_i) begin
         r_dropped <= 1'b0;
      end
   end

`ifdef BSG_COUNTER_OVERFLOW_EVENT_DROP_COUNT_EN
   logic [c_drop_count_width-1:0] r_drop_count;

   // Saturating lost-wrap count; clear restarts it, counting a same-cycle drop
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_drop_count <= '0;
      end else if (w_drop) begin
         if (clear_i) begin
            r_drop_count <= c_drop_count_width'(1);
         end else if (r_drop_count != '1) begin
            r_drop_count <= r_drop_count + 1'b1;
         end
      end else if (clear_i) begin
         r_drop_count <= '0;
      end
   end

   assign drop_count_o = r_drop_count;
`endif

   assign v_o       = (w_pending != '0);
   assign epoch_o   = r_epoch;
   assign pending_o = w_pending;
   assign dropped_o = r_dropped;

   // Consumer must not take a token that is not offered
   a_yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o));

endmodule
`default_nettype wire

// File: tb/tb_bsg_counter_overflow_event.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bsg_counter_overflow_event
//  Purpose  : Directed testbench with token scoreboard for the overflow-event
//             block (pending_width_p = 4, epoch_width_p = 4). Drop-count
//             checks are included when BSG_COUNTER_OVERFLOW_EVENT_DROP_COUNT_EN
//             is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_counter_overflow_event;

   localparam int PW = 4;
   localparam int EW = 4;

   logic          clk_i = 1'b0;
   logic          reset_i;
   logic          overflow_i;
   logic          arm_i;
   logic          disarm_i;
   logic          clear_i;
   logic          yumi_i;
   logic          v_o;
   logic [EW-1:0] epoch_o;
   logic [PW-1:0] pending_o;
   logic          dropped_o;
`ifdef BSG_COUNTER_OVERFLOW_EVENT_DROP_COUNT_EN
   logic [15:0]   drop_count_o;
`endif

   int            n_checks = 0;
   int            n_pass   = 0;
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] mon_exp;

   always #5 clk_i = ~clk_i;

   bsg_counter_overflow_event #(
      .pending_width_p (PW),
      .epoch_width_p   (EW)
   ) dut (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .overflow_i (overflow_i),
      .arm_i      (arm_i),
      .disarm_i   (disarm_i),
      .clear_i    (clear_i),
      .v_o        (v_o),
      .epoch_o    (epoch_o),
      .yumi_i     (yumi_i),
      .pending_o  (pending_o),
      .dropped_o  (dropped_o)
`ifdef BSG_COUNTER_OVERFLOW_EVENT_DROP_COUNT_EN
     ,.drop_count_o (drop_count_o)
`endif
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   // Monitor: every accepted token must carry the next expected epoch
   always @(negedge clk_i) begin
      if (!reset_i && v_o && yumi_i) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL token_unexpected: got epoch %0d, expected no token", epoch_o);
         end else begin
            mon_exp = exp_q.pop_front();
            check("token_epoch", int'(epoch_o), int'(mon_exp));
         end
      end
   end

   initial begin
      reset_i    = 1'b1;
      overflow_i = 1'b0;
      arm_i      = 1'b0;
      disarm_i   = 1'b0;
      clear_i    = 1'b0;
      yumi_i     = 1'b0;
      tick;
      check("rst_v", int'(v_o), 0);
      check("rst_pending", int'(pending_o), 0);
      check("rst_epoch", int'(epoch_o), 0);
      check("rst_dropped", int'(dropped_o), 0);
      #2 reset_i = 1'b0;

      // Arm, single wrap, single token
      tick;
      arm_i = 1'b1;
      tick;
      arm_i = 1'b0;
      overflow_i = 1'b1;
      exp_q.push_back(EW'(0));
      tick;
      overflow_i = 1'b0;
      check("single_v", int'(v_o), 1);
      check("single_pending", int'(pending_o), 1);
      check("single_epoch", int'(epoch_o), 0);
      yumi_i = 1'b1;
      tick;
      yumi_i = 1'b0;
      check("single_v_after_yumi", int'(v_o), 0);
      check("single_epoch_after_yumi", int'(epoch_o), 1);

      // Wraps while disarmed are ignored and not drops
      disarm_i = 1'b1;
      tick;
      disarm_i = 1'b0;
      overflow_i = 1'b1;
      tick;
      tick;
      overflow_i = 1'b0;
      check("disarmed_v", int'(v_o), 0);
      check("disarmed_pending", int'(pending_o), 0);
      check("disarmed_dropped", int'(dropped_o), 0);

      // 17 wraps with no consumer: 15 buffered, 2 dropped
      arm_i = 1'b1;
      tick;
      arm_i = 1'b0;
      for (int i = 0; i < 17; i++) begin
         overflow_i = 1'b1;
         if (i < 15) exp_q.push_back(EW'(i + 1));
         tick;
      end
      overflow_i = 1'b0;
      check("full_pending", int'(pending_o), 15);
      check("full_v", int'(v_o), 1);
      check("full_dropped", int'(dropped_o), 1);
`ifdef BSG_COUNTER_OVERFLOW_EVENT_DROP_COUNT_EN
      check("full_drop_count", int'(drop_count_o), 2);
`endif

      // In FULL, wrap plus consume in the same cycle: no change, no drop
      overflow_i = 1'b1;
      yumi_i     = 1'b1;
      exp_q.push_back(EW'(0));
      tick;
      overflow_i = 1'b0;
      yumi_i     = 1'b0;
      check("swap_pending", int'(pending_o), 15);
      check("swap_epoch", int'(epoch_o), 2);
      check("swap_dropped", int'(dropped_o), 1);
`ifdef BSG_COUNTER_OVERFLOW_EVENT_DROP_COUNT_EN
      check("swap_drop_count", int'(drop_count_o), 2);
`endif

      // Clear only touches the drop indication
      clear_i = 1'b1;
      tick;
      clear_i = 1'b0;
      check("clear_dropped", int'(dropped_o), 0);
      check("clear_pending", int'(pending_o), 15);
      check("clear_epoch", int'(epoch_o), 2);
`ifdef BSG_COUNTER_OVERFLOW_EVENT_DROP_COUNT_EN
      check("clear_drop_count", int'(drop_count_o), 0);
`endif

      // Clear and a new drop together: the drop wins
      clear_i    = 1'b1;
      overflow_i = 1'b1;
      tick;
      clear_i    = 1'b0;
      overflow_i = 1'b0;
      check("clrdrop_dropped", int'(dropped_o), 1);
      check("clrdrop_pending", int'(pending_o), 15);
`ifdef BSG_COUNTER_OVERFLOW_EVENT_DROP_COUNT_EN
      check("clrdrop_drop_count", int'(drop_count_o), 1);
`endif
      clear_i = 1'b1;
      tick;
      clear_i = 1'b0;
      check("clear2_dropped", int'(dropped_o), 0);

      // Drain all 15 tokens back-to-back; epoch wraps 15 -> 0 on the way
      yumi_i = 1'b1;
      repeat (15) tick;
      yumi_i = 1'b0;
      check("drain_v", int'(v_o), 0);
      check("drain_pending", int'(pending_o), 0);
      check("drain_epoch", int'(epoch_o), 1);

      // Buffer 3 wraps, then reset mid-cycle: outputs go to reset values at once
      overflow_i = 1'b1;
      repeat (3) tick;
      overflow_i = 1'b0;
      check("prereset_pending", int'(pending_o), 3);
      #2 reset_i = 1'b1;
      #1;
      check("async_rst_v", int'(v_o), 0);
      check("async_rst_pending", int'(pending_o), 0);
      check("async_rst_epoch", int'(epoch_o), 0);
      check("async_rst_dropped", int'(dropped_o), 0);
      #3 reset_i = 1'b0;

      // After reset the block is disarmed again
      overflow_i = 1'b1;
      tick;
      overflow_i = 1'b0;
      check("post_rst_v", int'(v_o), 0);
      check("post_rst_pending", int'(pending_o), 0);

      tick;
      check("scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bsg_counter_overflow_event.md
# bsg_counter_overflow_event

Downstream consumer of an overflowing counter's one-cycle `overflow` pulse. It converts each wrap event into a token on a valid/yumi output interface. Each token carries a monotonically increasing epoch number. The block buffers up to a bounded number of undelivered wraps and flags any wraps it drops. Software and arbiter logic read epochs from it instead of sampling the raw overflow wire.

## Interface
- `pending_width_p`, default 4: width of the pending-event counter. The maximum number of buffered wraps is 2^`pending_width_p` − 1.
- `epoch_width_p`, default 16: width of the epoch number carried by each token.

Ports:
- `clk_i`, in, 1: the single clock.
- `reset_i`, in, 1: asynchronous, active-high reset.
- `overflow_i`, in, 1: one-cycle wrap pulse from the upstream counter.
- `arm_i`, in, 1: start accepting wraps.
- `disarm_i`, in, 1: stop accepting wraps.
- `clear_i`, in, 1: clear the drop indication.
- `v_o`, out, 1: a token is available.
- `epoch_o`, out, `epoch_width_p`: epoch of the current token. Valid only while `v_o` is high.
- `yumi_i`, in, 1: consumer takes the token this cycle. Legal only while `v_o` is high.
- `pending_o`, out, `pending_width_p`: number of wraps currently buffered.
- `dropped_o`, out, 1: sticky flag. Set when at least one wrap was lost.

## Operation
- Reset values:
  - state DISARMED
  - `pending_o` = 0
  - epoch = 0
  - `v_o` = 0
  - `dropped_o` = 0
  - drop count = 0
- States:
  - DISARMED: `overflow_i` is ignored and does not count as a drop.
  - ARMED: each `overflow_i` increments pending.
  - FULL: pending is at maximum. An `overflow_i` without a same-cycle `yumi_i` sets `dropped_o`.
- Transitions:
  - DISARMED→ARMED on `arm_i`.
  - ARMED/FULL→DISARMED on `disarm_i`.
  - ARMED→FULL when next pending equals the maximum.
  - FULL→ARMED when next pending is below the maximum.
  - If `arm_i` and `disarm_i` are high together, `disarm_i` wins.
- Pending update per cycle: next = pending + (accepted overflow) − `yumi_i`.
  - Overflow and `yumi_i` in the same cycle leave pending unchanged, even in FULL. This is not a drop.
  - Pending never wraps.
- `v_o` = (pending ≠ 0). Buffered tokens still drain in DISARMED.
- `epoch_o` is the epoch register. It increments on each `yumi_i` and wraps from 2^`epoch_width_p` − 1 to 0.
- `clear_i` clears `dropped_o` and the drop count. It never touches pending or epoch.
  - If `clear_i` and a new drop occur in the same cycle, the drop wins: `dropped_o` = 1, drop count = 1.
- `yumi_i` while `v_o` = 0 is illegal. Assert it in simulation. RTL ignores it.

## Timing
- `overflow_i` at cycle t makes `v_o` high at t+1 (registered). There is no combinational path from `overflow_i` to `v_o`.
- `yumi_i` at cycle t: the epoch increments at t+1. `v_o` falls at t+1 if pending reaches 0.
- Back-to-back `yumi_i` gives one token per cycle.
- Every output is a register or a decode of a register. `yumi_i` has no combinational path to any output.
- `reset_i` asserted mid-operation immediately forces all reset values. Buffered tokens are discarded.

## Configuration
- `BSG_COUNTER_OVERFLOW_EVENT_DROP_COUNT_EN`:
  - Defined: adds output `drop_count_o` [15:0]. It counts lost wraps, saturates at 16'hFFFF, and is cleared by `clear_i` and reset.
  - Undefined: the port and its counter are absent. `dropped_o` alone reports loss.

## Structure
- Shared package `bsg_counter_overflow_event_pkg`:
  - state enum `bsg_overflow_event_state_e` {eDisarmed, eArmed, eFull}
  - drop-count width constant = 16
- Sub-module: the pending counter is an instance of `bsg_counter_up_down` (max_val = 2^`pending_width_p` − 1, up = accepted overflow, down = `yumi_i`).
- The FSM, epoch register and drop logic stay in the top.

## Test plan
- Reset, `arm_i`, single `overflow_i` at cycle 5 → `v_o` = 1 at cycle 6, `epoch_o` = 0; `yumi_i` at 6 → `v_o` = 0 and epoch = 1 at 7.
- `overflow_i` while DISARMED → `v_o` stays 0, `pending_o` = 0, `dropped_o` = 0.
- With `pending_width_p` = 4, 17 overflows and no `yumi_i` → `pending_o` = 15, state FULL, `dropped_o` = 1, `drop_count_o` = 2 (macro defined).
- In FULL, `overflow_i` and `yumi_i` in the same cycle → `pending_o` stays 15, no new drop; then `clear_i` → `dropped_o` = 0, pending unchanged.
- `epoch_width_p` = 4, 17 tokens consumed → epochs 0..15, then 0 again.
- Assert `reset_i` while `pending_o` = 3 → all outputs at reset values that same cycle; DISARMED after release.
